// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo family: packer FSM states and default word width.
package fifo_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } pack_state_e;

    localparam int DEFAULT_DATA_WIDTH = 4;

endpackage

// File: rtl/packer_lane_reg.sv
// Packed lane register: writes one DATA_WIDTH lane selected by index, and can zero
// every lane in the same cycle, with the write landing on top of the zeroed value.
module packer_lane_reg #(
    parameter int DATA_WIDTH = 4,
    parameter int PACK_RATIO = 2,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                             clk,
    input  logic                             zero_i,
    input  logic                             wr_en_i,
    input  logic [IDX_WIDTH-1:0]             wr_idx_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    output logic [PACK_RATIO*DATA_WIDTH-1:0] data_o
);

    logic [PACK_RATIO*DATA_WIDTH-1:0] data_q;
    logic [PACK_RATIO*DATA_WIDTH-1:0] data_d;

    always_comb begin
        data_d = zero_i ? '0 : data_q;
        if (wr_en_i) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (wr_idx_i == IDX_WIDTH'(i)) begin
                    data_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/fifo_deq_packer.sv
// Drains a first-word-fall-through fifo and packs PACK_RATIO words per output beat.
// Define PACKER_TIMEOUT_EN to flush partial packets after TIMEOUT_CYCLES idle cycles.
module fifo_deq_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PACK_RATIO     = 2,
    parameter int COUNT_WIDTH    = $clog2(PACK_RATIO + 1),
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic [DATA_WIDTH-1:0]            fifo_dout,
    input  logic                             fifo_empty_n,
    output logic                             fifo_deq,
    output logic [PACK_RATIO*DATA_WIDTH-1:0] pkt_data,
    output logic [COUNT_WIDTH-1:0]           pkt_lanes,
    output logic                             pkt_valid,
    input  logic                             pkt_ready
);

    pack_state_e            state_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] pkt_lanes_q;
    logic                   pkt_valid_q;
    logic                   accept;
    logic                   lane_zero;
    logic [COUNT_WIDTH-1:0] wr_idx;

`ifdef PACKER_TIMEOUT_EN
    localparam int IDLE_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_WIDTH-1:0] idle_q;
`endif

    assign accept    = (state_q == HOLD) && pkt_ready;
    assign fifo_deq  = fifo_empty_n && !rst && !clr && ((state_q == COLLECT) || pkt_ready);
    // Leaving HOLD zeroes the old packet while the popped word lands in lane 0.
    assign lane_zero = rst || clr || accept;
    assign wr_idx    = (state_q == HOLD) ? '0 : count_q;

    packer_lane_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK_RATIO (PACK_RATIO),
        .IDX_WIDTH  (COUNT_WIDTH)
    ) u_lanes (
        .clk       (clk),
        .zero_i    (lane_zero),
        .wr_en_i   (fifo_deq),
        .wr_idx_i  (wr_idx),
        .wr_data_i (fifo_dout),
        .data_o    (pkt_data)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            pkt_valid_q <= 1'b0;
            pkt_lanes_q <= '0;
`ifdef PACKER_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (fifo_deq) begin
                        count_q <= count_q + COUNT_WIDTH'(1);
`ifdef PACKER_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                        if (count_q == COUNT_WIDTH'(PACK_RATIO - 1)) begin
                            state_q     <= HOLD;
                            pkt_valid_q <= 1'b1;
                            pkt_lanes_q <= COUNT_WIDTH'(PACK_RATIO);
                        end
                    end
`ifdef PACKER_TIMEOUT_EN
                    else if (count_q != '0) begin
                        if (idle_q == IDLE_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                            state_q     <= HOLD;
                            pkt_valid_q <= 1'b1;
                            pkt_lanes_q <= count_q;
                            idle_q      <= '0;
                        end else begin
                            idle_q <= idle_q + IDLE_WIDTH'(1);
                        end
                    end
`endif
                end
                HOLD: begin
                    if (pkt_ready) begin
                        state_q     <= COLLECT;
                        pkt_valid_q <= 1'b0;
                        pkt_lanes_q <= '0;
                        count_q     <= fifo_deq ? COUNT_WIDTH'(1) : '0;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_lanes = pkt_lanes_q;

endmodule
